// File: rtl/idex_pipe_stage.sv
// -----------------------------------------------------------------------------
// idex_pipe_stage
//   ID->EX pipeline stage with per-instruction valid bit, ready/valid handshake
//   backed by a 1-entry skid buffer, and a redirect flush. The stored regWrite
//   is killed for rd==0 and gated by the valid bit, so EX forwarding/hazard
//   logic never sees a write from a bubble.
//
// Ports
//   CLK, RST                    clock (posedge) and synchronous active-high reset
//   in_valid / in_ready         ID-side handshake (in_ready = no skid entry held)
//   flush                       drop everything held plus the same-cycle input
//   In*                         ID payload (PC, operands, addresses, selects,
//                               register indices, regWrite)
//   out_valid / out_ready       EX-side handshake
//   PC ... IDEXrd               registered payload presented to EX
//   IDEXregWrite                stored regWrite qualified by out_valid
// -----------------------------------------------------------------------------
module idex_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int REGIDX_W = 5,
  parameter int SRCB_W   = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic [XLEN-1:0]     InPC,
  input  logic [XLEN-1:0]     Inrs1val,
  input  logic [XLEN-1:0]     Inrs2val,
  input  logic [XLEN-1:0]     InLoadStoreOrjalAddress,
  input  logic [XLEN-1:0]     InauipcOrlui,
  input  logic [XLEN-1:0]     InLoadStore32Address,
  input  logic                InALUSourceA,
  input  logic [SRCB_W-1:0]   InALUSourceB,
  input  logic [REGIDX_W-1:0] InIDEXrs1,
  input  logic [REGIDX_W-1:0] InIDEXrs2,
  input  logic [REGIDX_W-1:0] InIDEXrd,
  input  logic                InIDEXregWrite,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     rs1val,
  output logic [XLEN-1:0]     rs2val,
  output logic [XLEN-1:0]     LoadStoreOrjalAddress,
  output logic [XLEN-1:0]     auipcOrlui,
  output logic [XLEN-1:0]     LoadStore32Address,
  output logic                ALUSourceA,
  output logic [SRCB_W-1:0]   ALUSourceB,
  output logic [REGIDX_W-1:0] IDEXrs1,
  output logic [REGIDX_W-1:0] IDEXrs2,
  output logic [REGIDX_W-1:0] IDEXrd,
  output logic                IDEXregWrite
);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1val;
    logic [XLEN-1:0]     rs2val;
    logic [XLEN-1:0]     lsj_addr;
    logic [XLEN-1:0]     auipc_lui;
    logic [XLEN-1:0]     ls32_addr;
    logic                srca;
    logic [SRCB_W-1:0]   srcb;
    logic [REGIDX_W-1:0] rs1;
    logic [REGIDX_W-1:0] rs2;
    logic [REGIDX_W-1:0] rd;
    logic                regwrite;
  } payload_t;

  payload_t main_r;
  payload_t skid_r;
  logic     main_valid_r;
  logic     skid_valid_r;

  payload_t in_payload_s;
  logic     accept_s;
  logic     advance_s;

  // Pack the incoming payload; a write to x0 is dropped at the door.
  always_comb begin
    in_payload_s           = '0;
    in_payload_s.pc        = InPC;
    in_payload_s.rs1val    = Inrs1val;
    in_payload_s.rs2val    = Inrs2val;
    in_payload_s.lsj_addr  = InLoadStoreOrjalAddress;
    in_payload_s.auipc_lui = InauipcOrlui;
    in_payload_s.ls32_addr = InLoadStore32Address;
    in_payload_s.srca      = InALUSourceA;
    in_payload_s.srcb      = InALUSourceB;
    in_payload_s.rs1       = InIDEXrs1;
    in_payload_s.rs2       = InIDEXrs2;
    in_payload_s.rd        = InIDEXrd;
    in_payload_s.regwrite  = InIDEXregWrite & (InIDEXrd != {REGIDX_W{1'b0}});
  end

  // Handshake decode: in_ready comes only from the skid flag, so there is no
  // combinational path from out_ready back to ID.
  always_comb begin
    accept_s  = 1'b0;
    advance_s = 1'b0;
    if (in_valid && !skid_valid_r && !flush) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    advance_s = out_ready | ~main_valid_r;
  end

  // Main/skid storage. Payload registers only load when they capture an
  // instruction; the valid bits alone decide what is live.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      // Anything EX consumed this cycle is already gone; drop the rest.
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (advance_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        main_r       <= in_payload_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      // Main is stalled and holding: park the new instruction in the skid.
      skid_r       <= in_payload_s;
      skid_valid_r <= 1'b1;
    end else begin
      main_valid_r <= main_valid_r;
      skid_valid_r <= skid_valid_r;
    end
  end

  assign in_ready              = ~skid_valid_r;
  assign out_valid             = main_valid_r;
  assign PC                    = main_r.pc;
  assign rs1val                = main_r.rs1val;
  assign rs2val                = main_r.rs2val;
  assign LoadStoreOrjalAddress = main_r.lsj_addr;
  assign auipcOrlui            = main_r.auipc_lui;
  assign LoadStore32Address    = main_r.ls32_addr;
  assign ALUSourceA            = main_r.srca;
  assign ALUSourceB            = main_r.srcb;
  assign IDEXrs1               = main_r.rs1;
  assign IDEXrs2               = main_r.rs2;
  assign IDEXrd                = main_r.rd;
  assign IDEXregWrite          = main_r.regwrite & main_valid_r;

endmodule
